// File: rtl/tetris_key_conditioner.sv
// Push-button conditioner for the tetris controls: synchronise, debounce and
// edge-detect the four active-low KEYs, with auto-repeat on left/down/right.
module tetris_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 6250000,
    parameter int unsigned REPEAT_RATE     = 1250000,
    parameter int unsigned CNT_W           = 23
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       up_n,
    input  logic       left_n,
    input  logic       down_n,
    input  logic       right_n,
    input  logic       stop,
    output logic       up_p,
    output logic       left_p,
    output logic       down_p,
    output logic       right_p,
    output logic [3:0] held
);

    localparam int unsigned NKEY = 4;
    localparam int unsigned NREP = 3;
    localparam int unsigned KR   = 0;
    localparam int unsigned KD   = 1;
    localparam int unsigned KL   = 2;
    localparam int unsigned KU   = 3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    logic [NKEY-1:0]  sync1_q, sync1_d;
    logic [NKEY-1:0]  sync2_q, sync2_d;
    logic [NKEY-1:0]  held_q, held_d;
    logic [NKEY-1:0]  pulse_q, pulse_d;
    logic [CNT_W-1:0] db_cnt_q [NKEY];
    logic [CNT_W-1:0] db_cnt_d [NKEY];
    rep_state_e       rep_st_q [NREP];
    rep_state_e       rep_st_d [NREP];
    logic [CNT_W-1:0] rep_cnt_q [NREP];
    logic [CNT_W-1:0] rep_cnt_d [NREP];

    logic [NKEY-1:0]  pressed_c;
    logic [NKEY-1:0]  rise_c;
    logic [NKEY-1:0]  press_ok_c;
    logic [NREP-1:0]  rep_fire_c;
    logic             opposed_c;

    // Two-flop synchroniser on the raw active-low levels; resets to released.
    always_comb begin
        sync1_d   = {up_n, left_n, down_n, right_n};
        sync2_d   = sync1_q;
        pressed_c = ~sync2_q;
    end

    // Debounce: a state change is accepted only after it has persisted.
    always_comb begin
        held_d = held_q;
        for (int unsigned k = 0; k < NKEY; k++) begin
            db_cnt_d[k] = '0;
            if (pressed_c[k] != held_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    held_d[k] = ~held_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    // Press pulses and auto-repeat FSMs, evaluated against next-cycle held.
    always_comb begin
        rise_c     = held_d & ~held_q;
        opposed_c  = held_d[KL] & held_d[KR];
        press_ok_c = stop ? '0 : rise_c;
        rep_fire_c = '0;
        if (rise_c[KL] && rise_c[KR]) begin
            press_ok_c[KL] = 1'b0;
            press_ok_c[KR] = 1'b0;
        end
        for (int unsigned k = 0; k < NREP; k++) begin
            rep_st_d[k]  = rep_st_q[k];
            rep_cnt_d[k] = rep_cnt_q[k];
            if (!held_d[k] || stop || opposed_c) begin
                rep_st_d[k]  = REP_IDLE;
                rep_cnt_d[k] = '0;
            end else begin
                case (rep_st_q[k])
                    REP_IDLE: begin
                        if (press_ok_c[k]) begin
                            rep_st_d[k]  = REP_DELAY;
                            rep_cnt_d[k] = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (rep_cnt_q[k] == RD_LAST) begin
                            rep_fire_c[k] = 1'b1;
                            rep_st_d[k]   = REP_REPEAT;
                            rep_cnt_d[k]  = '0;
                        end else begin
                            rep_cnt_d[k] = rep_cnt_q[k] + CNT_ONE;
                        end
                    end
                    REP_REPEAT: begin
                        if (rep_cnt_q[k] == RR_LAST) begin
                            rep_fire_c[k] = 1'b1;
                            rep_cnt_d[k]  = '0;
                        end else begin
                            rep_cnt_d[k] = rep_cnt_q[k] + CNT_ONE;
                        end
                    end
                    default: begin
                        rep_st_d[k]  = REP_IDLE;
                        rep_cnt_d[k] = '0;
                    end
                endcase
            end
        end
        pulse_d = press_ok_c | {1'b0, rep_fire_c};
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            held_q  <= '0;
            pulse_q <= '0;
            for (int unsigned k = 0; k < NKEY; k++) begin
                db_cnt_q[k] <= '0;
            end
            for (int unsigned k = 0; k < NREP; k++) begin
                rep_st_q[k]  <= REP_IDLE;
                rep_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            for (int unsigned k = 0; k < NKEY; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
            for (int unsigned k = 0; k < NREP; k++) begin
                rep_st_q[k]  <= rep_st_d[k];
                rep_cnt_q[k] <= rep_cnt_d[k];
            end
        end
    end

    assign up_p    = pulse_q[KU];
    assign left_p  = pulse_q[KL];
    assign down_p  = pulse_q[KD];
    assign right_p = pulse_q[KR];
    assign held    = held_q;

endmodule
